id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: Clk  in  1  rising-edge clock.
REQ-002 SHALL have: Reset  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: Instr_In  in  32  IF/ID instruction; Instr_Valid  in  1  IF/ID slot holds a real instruction.
REQ-004 SHALL have: Read_Reg_Num_1 / Read_Reg_Num_2  out  5  to register file, combinationally Instr_In[25:21] / [20:16].
REQ-005 SHALL have: Read_Data_1_In / Read_Data_2_In  in  32  register-file read data, same cycle.
REQ-006 SHALL have: WB_RegWrite  in  1; WB_Reg_Num  in  5; WB_Data  in  32  writeback port, same signals that drive the register-file write.
REQ-007 SHALL have: Flush  in  1  discard the decoding instruction (taken branch).
REQ-008 SHALL have registered outputs: EX_Valid 1; EX_Rs_Data 32; EX_Rt_Data 32; EX_Rs 5; EX_Rt 5; EX_Dest 5; EX_Imm 32; EX_Opcode 6; EX_Funct 6; EX_RegWrite 1; EX_MemRead 1; EX_MemWrite 1; Bubble_Count 16.
REQ-009 SHALL have: Stall  out  1  combinational; freezes PC and IF/ID.

Function
REQ-010 Decode SHALL be: opcode 0x00 R-type (RegWrite, Dest=rd, uses rs,rt); 0x23 lw (MemRead, RegWrite, Dest=rt, uses rs); 0x2B sw (MemWrite, uses rs,rt); 0x08 addi (RegWrite, Dest=rt, uses rs); 0x04 beq (no write, uses rs,rt); any other opcode SHALL decode as nop (all controls 0, Dest=0).
REQ-011 EX_Imm SHALL be Instr_In[15:0] sign-extended to 32 bits.
REQ-012 A decoded Dest of 0 SHALL force EX_RegWrite=0.
REQ-013 Source data: register number 0 SHALL read as 32'h0 regardless of Read_Data input.
REQ-014 Stall SHALL be 1 iff Instr_Valid=1, Flush=0, EX_Valid=1, EX_MemRead=1, EX_Dest!=0, and EX_Dest equals rs, or equals rt for an instruction that uses rt.
REQ-015 Per clock edge, priority: Reset, then Flush, then Stall, then normal capture.
REQ-016 Flush=1 or Instr_Valid=0: next EX_Valid=0, EX_RegWrite=EX_MemRead=EX_MemWrite=0; data fields don't-care but SHALL be held.
REQ-017 Stall=1: SHALL insert a bubble (as REQ-016) and increment Bubble_Count; Bubble_Count SHALL saturate at 16'hFFFF.
REQ-018 Normal capture: all EX_* fields SHALL take decoded/read values with latency exactly one cycle; EX_Valid=1.
REQ-019 A load-use stall SHALL last exactly one cycle; the following cycle the bubble in EX clears the hazard and the held instruction is captured.
REQ-020 Flush asserted together with a hazard SHALL yield Stall=0 and no Bubble_Count increment.

Reset
REQ-021 Reset=0 at a clock edge SHALL set every registered output, including Bubble_Count, to 0.
REQ-022 Reset SHALL override Flush, Stall and capture; Stall SHALL read 0 while EX_Valid=0 after reset.
REQ-023 Reset mid-stall SHALL cancel the stall; the held instruction is re-presented by upstream after release.

Configuration
REQ-024 Macro WB_BYPASS_EN SHALL control writeback bypass.
REQ-025 Defined: if WB_RegWrite=1, WB_Reg_Num!=0 and WB_Reg_Num equals rs (rt), captured EX_Rs_Data (EX_Rt_Data) SHALL be WB_Data instead of register-file data (write-through same cycle).
REQ-026 Undefined: captured data SHALL be Read_Data_x_In directly (register file assumed write-first internally); all other behaviour identical.

Verification
REQ-027 Reset=0 one cycle then add $t2,$t0,$t1 (0x01095020... rs=8,rt=9,rd=10) with inputs 6,7 -> next cycle EX_Valid=1, EX_Rs_Data=6, EX_Rt_Data=7, EX_Dest=10, EX_RegWrite=1.
REQ-028 lw $t0,4($s2) captured, then add $t1,$t0,$t0 presented -> Stall=1 one cycle, EX_Valid=0, Bubble_Count=1; following cycle add captured, Stall=0.
REQ-029 Same lw then addi $t1,$s0,1 (rt=$t1 not a source) -> Stall=0, Bubble_Count stays 0.
REQ-030 Hazard case of REQ-028 with Flush=1 -> Stall=0, EX_Valid=0, Bubble_Count unchanged.
REQ-031 WB_BYPASS_EN defined: WB writes $t0=0x55 while add uses $t0, Read_Data_1_In=0x01 -> EX_Rs_Data=0x55; WB_Reg_Num=0 -> no bypass.
REQ-032 Instruction rs=0 with Read_Data_1_In=0xDEADBEEF -> EX_Rs_Data=0; addi with rt=0 -> EX_RegWrite=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decode, register-file read, load-use hazard detect, EX register bank.
// Latency: one cycle from Instr_In to the EX_* registers; Stall is combinational from EX state.
// Backpressure: a load-use hazard raises Stall for one cycle and inserts a bubble; Flush drops the slot.
// Optional feature: define WB_BYPASS_EN to forward the same-cycle writeback value into source data.
module id_ex_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr_In,
    input  logic        Instr_Valid,
    output logic [4:0]  Read_Reg_Num_1,
    output logic [4:0]  Read_Reg_Num_2,
    input  logic [31:0] Read_Data_1_In,
    input  logic [31:0] Read_Data_2_In,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_Reg_Num,
    input  logic [31:0] WB_Data,
    input  logic        Flush,
    output logic        EX_Valid,
    output logic [31:0] EX_Rs_Data,
    output logic [31:0] EX_Rt_Data,
    output logic [4:0]  EX_Rs,
    output logic [4:0]  EX_Rt,
    output logic [4:0]  EX_Dest,
    output logic [31:0] EX_Imm,
    output logic [5:0]  EX_Opcode,
    output logic [5:0]  EX_Funct,
    output logic        EX_RegWrite,
    output logic        EX_MemRead,
    output logic        EX_MemWrite,
    output logic [15:0] Bubble_Count,
    output logic        Stall
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] imm_ext;

    logic        dec_regwrite;
    logic        dec_memread;
    logic        dec_memwrite;
    logic        dec_uses_rt;
    logic [4:0]  dec_dest;

    logic [31:0] rs_data;
    logic [31:0] rt_data;

    assign opcode  = Instr_In[31:26];
    assign rs      = Instr_In[25:21];
    assign rt      = Instr_In[20:16];
    assign rd      = Instr_In[15:11];
    assign funct   = Instr_In[5:0];
    assign imm_ext = {{16{Instr_In[15]}}, Instr_In[15:0]};

    assign Read_Reg_Num_1 = rs;
    assign Read_Reg_Num_2 = rt;

    // Opcode decode into control bits; unknown opcodes behave as a nop with no destination.
    always_comb begin
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_uses_rt  = 1'b0;
        dec_dest     = 5'd0;
        case (opcode)
            OP_RTYPE: begin
                dec_regwrite = 1'b1;
                dec_uses_rt  = 1'b1;
                dec_dest     = rd;
            end
            OP_LW: begin
                dec_memread  = 1'b1;
                dec_regwrite = 1'b1;
                dec_dest     = rt;
            end
            OP_SW: begin
                dec_memwrite = 1'b1;
                dec_uses_rt  = 1'b1;
            end
            OP_ADDI: begin
                dec_regwrite = 1'b1;
                dec_dest     = rt;
            end
            OP_BEQ: begin
                dec_uses_rt  = 1'b1;
            end
            default: begin
                dec_regwrite = 1'b0;
            end
        endcase
    end

`ifdef WB_BYPASS_EN
    // Source operands: $zero reads as 0, otherwise the writeback value wins over a stale file read.
    always_comb begin
        rs_data = Read_Data_1_In;
        rt_data = Read_Data_2_In;
        if (WB_RegWrite && (WB_Reg_Num != 5'd0) && (WB_Reg_Num == rs)) rs_data = WB_Data;
        if (WB_RegWrite && (WB_Reg_Num != 5'd0) && (WB_Reg_Num == rt)) rt_data = WB_Data;
        if (rs == 5'd0) rs_data = 32'h0;
        if (rt == 5'd0) rt_data = 32'h0;
    end
`else
    // The register file is write-first, so the writeback port is only observed, never used here.
    logic unused_wb;
    assign unused_wb = ^{WB_RegWrite, WB_Reg_Num, WB_Data};

    // Source operands: $zero reads as 0, otherwise straight from the register file.
    always_comb begin
        rs_data = (rs == 5'd0) ? 32'h0 : Read_Data_1_In;
        rt_data = (rt == 5'd0) ? 32'h0 : Read_Data_2_In;
    end
`endif

    // Load-use hazard: a load in EX whose destination feeds this instruction's sources.
    assign Stall = Instr_Valid && !Flush && EX_Valid && EX_MemRead && (EX_Dest != 5'd0) &&
                   ((EX_Dest == rs) || (dec_uses_rt && (EX_Dest == rt)));

    // EX register bank: reset, then flush/empty slot, then stall bubble, then normal capture.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            EX_Valid     <= 1'b0;
            EX_Rs_Data   <= 32'h0;
            EX_Rt_Data   <= 32'h0;
            EX_Rs        <= 5'd0;
            EX_Rt        <= 5'd0;
            EX_Dest      <= 5'd0;
            EX_Imm       <= 32'h0;
            EX_Opcode    <= 6'd0;
            EX_Funct     <= 6'd0;
            EX_RegWrite  <= 1'b0;
            EX_MemRead   <= 1'b0;
            EX_MemWrite  <= 1'b0;
            Bubble_Count <= 16'h0;
        end else if (Flush || !Instr_Valid) begin
            EX_Valid    <= 1'b0;
            EX_RegWrite <= 1'b0;
            EX_MemRead  <= 1'b0;
            EX_MemWrite <= 1'b0;
        end else if (Stall) begin
            EX_Valid    <= 1'b0;
            EX_RegWrite <= 1'b0;
            EX_MemRead  <= 1'b0;
            EX_MemWrite <= 1'b0;
            if (Bubble_Count != 16'hFFFF) Bubble_Count <= Bubble_Count + 16'd1;
        end else begin
            EX_Valid    <= 1'b1;
            EX_Rs_Data  <= rs_data;
            EX_Rt_Data  <= rt_data;
            EX_Rs       <= rs;
            EX_Rt       <= rt;
            EX_Dest     <= dec_dest;
            EX_Imm      <= imm_ext;
            EX_Opcode   <= opcode;
            EX_Funct    <= funct;
            EX_RegWrite <= dec_regwrite && (dec_dest != 5'd0);
            EX_MemRead  <= dec_memread;
            EX_MemWrite <= dec_memwrite;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed load-use / flush / bypass cases, then random traffic.
// Driver issues inputs on the falling edge and queues the model's expected Stall and next EX state.
// Monitor checks Stall just before the rising edge and the registered outputs just after it.
module tb_id_ex_stage;

    logic        Clk;
    logic        Reset;
    logic [31:0] Instr_In;
    logic        Instr_Valid;
    logic [4:0]  Read_Reg_Num_1;
    logic [4:0]  Read_Reg_Num_2;
    logic [31:0] Read_Data_1_In;
    logic [31:0] Read_Data_2_In;
    logic        WB_RegWrite;
    logic [4:0]  WB_Reg_Num;
    logic [31:0] WB_Data;
    logic        Flush;
    logic        EX_Valid;
    logic [31:0] EX_Rs_Data;
    logic [31:0] EX_Rt_Data;
    logic [4:0]  EX_Rs;
    logic [4:0]  EX_Rt;
    logic [4:0]  EX_Dest;
    logic [31:0] EX_Imm;
    logic [5:0]  EX_Opcode;
    logic [5:0]  EX_Funct;
    logic        EX_RegWrite;
    logic        EX_MemRead;
    logic        EX_MemWrite;
    logic [15:0] Bubble_Count;
    logic        Stall;

    id_ex_stage dut (
        .Clk(Clk), .Reset(Reset), .Instr_In(Instr_In), .Instr_Valid(Instr_Valid),
        .Read_Reg_Num_1(Read_Reg_Num_1), .Read_Reg_Num_2(Read_Reg_Num_2),
        .Read_Data_1_In(Read_Data_1_In), .Read_Data_2_In(Read_Data_2_In),
        .WB_RegWrite(WB_RegWrite), .WB_Reg_Num(WB_Reg_Num), .WB_Data(WB_Data),
        .Flush(Flush), .EX_Valid(EX_Valid), .EX_Rs_Data(EX_Rs_Data), .EX_Rt_Data(EX_Rt_Data),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Dest(EX_Dest), .EX_Imm(EX_Imm),
        .EX_Opcode(EX_Opcode), .EX_Funct(EX_Funct), .EX_RegWrite(EX_RegWrite),
        .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .Bubble_Count(Bubble_Count), .Stall(Stall)
    );

    typedef struct packed {
        logic        vld;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [15:0] bc;
    } st_t;

    typedef struct {
        bit  chk_stall;
        bit  stall;
        st_t nxt;
    } sb_t;

    sb_t q[$];
    st_t m;
    bit  m_known = 1'b0;
    int  n_cmp = 0;
    int  n_err = 0;
    int  n_issued = 0;
    int  n_checked = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: computes what the EX register bank and Stall must be from the ISA rules.
    task automatic step(input logic rst, input logic vld, input logic flush,
                        input logic [31:0] instr, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic wbw, input logic [4:0] wbn, input logic [31:0] wbd);
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, dest;
        logic        w, mr, mw, uses_rt, stall;
        logic [31:0] a, b;
        st_t         n;
        sb_t         e;
        @(negedge Clk);
        Reset = rst; Instr_Valid = vld; Flush = flush; Instr_In = instr;
        Read_Data_1_In = rd1; Read_Data_2_In = rd2;
        WB_RegWrite = wbw; WB_Reg_Num = wbn; WB_Data = wbd;

        op = instr[31:26]; rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
        w = 0; mr = 0; mw = 0; uses_rt = 0; dest = 0;
        if (op == 6'h00)      begin w = 1; dest = rd; uses_rt = 1; end
        else if (op == 6'h23) begin w = 1; mr = 1; dest = rt; end
        else if (op == 6'h2B) begin mw = 1; uses_rt = 1; end
        else if (op == 6'h08) begin w = 1; dest = rt; end
        else if (op == 6'h04) begin uses_rt = 1; end
        if (dest == 0) w = 0;

        a = rd1; b = rd2;
`ifdef WB_BYPASS_EN
        if (wbw && wbn != 0 && wbn == rs) a = wbd;
        if (wbw && wbn != 0 && wbn == rt) b = wbd;
`endif
        if (rs == 0) a = 0;
        if (rt == 0) b = 0;

        stall = vld && !flush && m.vld && m.mr && m.dest != 0 &&
                (m.dest == rs || (uses_rt && m.dest == rt));

        n = m;
        if (!rst) begin
            n = '0;
        end else if (flush || !vld || stall) begin
            n.vld = 0; n.rw = 0; n.mr = 0; n.mw = 0;
            if (stall && !flush && vld && n.bc != 16'hFFFF) n.bc = n.bc + 1;
        end else begin
            n.vld = 1; n.rs_d = a; n.rt_d = b; n.rs = rs; n.rt = rt; n.dest = dest;
            n.imm = {{16{instr[15]}}, instr[15:0]}; n.op = op; n.fn = instr[5:0];
            n.rw = w; n.mr = mr; n.mw = mw;
        end
        e.chk_stall = m_known;
        e.stall = stall;
        e.nxt = n;
        q.push_back(e);
        n_issued++;
        m = n;
        m_known = 1'b1;
    endtask

    // Monitor: Stall just before the capturing edge, EX registers just after it.
    initial begin
        sb_t  e;
        st_t  got;
        forever begin
            @(negedge Clk);
            #4;
            if (q.size() > 0) begin
                e = q[0];
                if (e.chk_stall) begin
                    n_cmp++;
                    if (Stall !== e.stall) begin
                        n_err++;
                        $display("FAIL stall: got %b expected %b at %0t", Stall, e.stall, $time);
                    end
                end
                @(posedge Clk);
                #1;
                void'(q.pop_front());
                got = '{EX_Valid, EX_Rs_Data, EX_Rt_Data, EX_Rs, EX_Rt, EX_Dest, EX_Imm,
                        EX_Opcode, EX_Funct, EX_RegWrite, EX_MemRead, EX_MemWrite, Bubble_Count};
                n_cmp++;
                n_checked++;
                if (got !== e.nxt) begin
                    n_err++;
                    $display("FAIL ex_regs: got %h expected %h at %0t", got, e.nxt, $time);
                end
            end
        end
    end

    function automatic logic [4:0] rnd_reg();
        if ($urandom_range(0, 7) == 0) return 5'($urandom);
        return 5'($urandom_range(0, 3));
    endfunction

    // Directed cases first, then randomized traffic; constant checks sit after the capturing edge.
    initial begin
        logic [5:0]  op;
        logic [31:0] ins;
        logic [31:0] byp_exp;
        Reset = 1; Instr_Valid = 0; Flush = 0; Instr_In = 0;
        Read_Data_1_In = 0; Read_Data_2_In = 0;
        WB_RegWrite = 0; WB_Reg_Num = 0; WB_Data = 0;

        // reset, then add $t2,$t0,$t1
        step(0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
        @(posedge Clk); #2;
        chk("reset_valid", {31'b0, EX_Valid}, 0);
        chk("reset_bubbles", {16'b0, Bubble_Count}, 0);
        chk("reset_stall", {31'b0, Stall}, 0);
        step(1, 1, 0, 32'h01095020, 6, 7, 0, 0, 0);
        @(posedge Clk); #2;
        chk("add_valid", {31'b0, EX_Valid}, 1);
        chk("add_rs_data", EX_Rs_Data, 6);
        chk("add_rt_data", EX_Rt_Data, 7);
        chk("add_dest", {27'b0, EX_Dest}, 10);
        chk("add_regwrite", {31'b0, EX_RegWrite}, 1);

        // lw $t0,4($s2) then dependent add: one bubble, then capture
        step(1, 1, 0, 32'h8E480004, 3, 3, 0, 0, 0);
        step(1, 1, 0, 32'h01084820, 1, 1, 0, 0, 0);
        @(posedge Clk); #2;
        chk("lu_bubble_valid", {31'b0, EX_Valid}, 0);
        chk("lu_bubble_count", {16'b0, Bubble_Count}, 1);
        step(1, 1, 0, 32'h01084820, 1, 1, 0, 0, 0);
        @(posedge Clk); #2;
        chk("lu_capture_valid", {31'b0, EX_Valid}, 1);
        chk("lu_capture_dest", {27'b0, EX_Dest}, 9);
        chk("lu_capture_stall", {31'b0, Stall}, 0);

        // lw then independent addi $t1,$s0,1: no stall
        step(0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 32'h8E480004, 3, 3, 0, 0, 0);
        step(1, 1, 0, 32'h22090001, 4, 4, 0, 0, 0);
        @(posedge Clk); #2;
        chk("indep_valid", {31'b0, EX_Valid}, 1);
        chk("indep_bubbles", {16'b0, Bubble_Count}, 0);

        // lw then dependent add with Flush: no stall, no bubble count
        step(1, 1, 0, 32'h8E480004, 3, 3, 0, 0, 0);
        step(1, 1, 1, 32'h01084820, 1, 1, 0, 0, 0);
        @(posedge Clk); #2;
        chk("flush_valid", {31'b0, EX_Valid}, 0);
        chk("flush_bubbles", {16'b0, Bubble_Count}, 0);

        // writeback of $t0 during decode of an add reading $t0
`ifdef WB_BYPASS_EN
        byp_exp = 32'h55;
`else
        byp_exp = 32'h01;
`endif
        step(1, 1, 0, 32'h01095020, 32'h01, 32'h02, 1, 8, 32'h55);
        @(posedge Clk); #2;
        chk("wb_bypass", EX_Rs_Data, byp_exp);
        step(1, 1, 0, 32'h01095020, 32'h01, 32'h02, 1, 0, 32'h55);
        @(posedge Clk); #2;
        chk("wb_reg0_no_bypass", EX_Rs_Data, 32'h01);

        // $zero source and $zero destination
        step(1, 1, 0, 32'h00095020, 32'hDEADBEEF, 5, 0, 0, 0);
        @(posedge Clk); #2;
        chk("zero_src", EX_Rs_Data, 0);
        step(1, 1, 0, 32'h21000005, 9, 9, 0, 0, 0);
        @(posedge Clk); #2;
        chk("zero_dest_regwrite", {31'b0, EX_RegWrite}, 0);
        chk("zero_dest_valid", {31'b0, EX_Valid}, 1);
        chk("imm_sext", EX_Imm, 32'h5);
        step(1, 1, 0, 32'h2109FFFE, 9, 9, 0, 0, 0);
        @(posedge Clk); #2;
        chk("imm_sext_neg", EX_Imm, 32'hFFFFFFFE);

        // randomized traffic biased toward few registers so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = ($urandom_range(0, 1) == 0) ? 6'h08 : 6'h04;
                default: op = 6'($urandom);
            endcase
            ins = {op, rnd_reg(), rnd_reg(), rnd_reg(), 11'($urandom)};
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 9) == 0), ins, $urandom, $urandom,
                 1'($urandom), rnd_reg(), $urandom);
        end

        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge Clk);
        #3;
        n_cmp++;
        if (q.size() != 0 || n_checked != n_issued) begin
            n_err++;
            $display("FAIL drain: checked %0d of %0d issued", n_checked, n_issued);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
